// File: rtl/pmu_core_ovq.sv
// rtl/pmu_core_ovq.sv - PMU core with event counters, overflow status and quota engine
//
// Purpose: bank of N_COUNTERS event counters plus configuration registers,
// exchanged with a bus wrapper as a flat register array. Adds per-counter
// overflow detection (maskable, sticky) and a sequential quota engine that
// sums the selected counters and flags when the sum exceeds a limit.
//
// Ports:
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   regs_i         register image from the wrapper (TOTAL_NREGS x REG_WIDTH)
//   regs_o         internal register values to the wrapper
//   wrapper_we_i   load writable registers from regs_i this cycle
//   events_i       event pulses, one increment per high cycle
//   int_overflow_o overflow interrupt (registered OR of OVF_STATUS)
//   int_quota_o    sticky quota-exceeded interrupt
//
// Register map: 0 CFG (bit0 en, bit1 softrst), 1..N counters, N+1 OVF_MASK,
// N+2 OVF_STATUS (read-only), N+3 QUOTA_MASK, N+4 QUOTA_LIMIT.

module pmu_core_ovq #(
   parameter int  REG_WIDTH   = 32,
   parameter int  N_COUNTERS  = 9,
   localparam int TOTAL_NREGS = N_COUNTERS + 5,
   localparam int SUM_W       = REG_WIDTH + $clog2(N_COUNTERS)
) (
   input  logic                                  clk_i,
   input  logic                                  rstn_i,
   input  logic [TOTAL_NREGS-1:0][REG_WIDTH-1:0] regs_i,
   output logic [TOTAL_NREGS-1:0][REG_WIDTH-1:0] regs_o,
   input  logic                                  wrapper_we_i,
   input  logic [N_COUNTERS-1:0]                 events_i,
   output logic                                  int_overflow_o,
   output logic                                  int_quota_o
);

   localparam int IDX_W      = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
   localparam int OVF_MASK_I = N_COUNTERS + 1;
   localparam int OVF_STAT_I = N_COUNTERS + 2;
   localparam int Q_MASK_I   = N_COUNTERS + 3;
   localparam int Q_LIMIT_I  = N_COUNTERS + 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_COMPARE
   } state_e;

   // Control bits act in the same cycle they are presented by the wrapper.
   logic en;
   logic softrst;
   assign en      = regs_i[0][0];
   assign softrst = regs_i[0][1];

   // Bits of the wrapper image that have no storage behind them.
   logic unused_regs_bits;
   assign unused_regs_bits = ^{regs_i[0], regs_i[OVF_MASK_I], regs_i[OVF_STAT_I], regs_i[Q_MASK_I]};

   logic [1:0]            cfg_q;
   logic [REG_WIDTH-1:0]  cnt_q [N_COUNTERS];
   logic [REG_WIDTH-1:0]  cnt_d [N_COUNTERS];
   logic [N_COUNTERS-1:0] ovf_mask_q;
   logic [N_COUNTERS-1:0] ovf_status_q, ovf_status_d;
   logic [N_COUNTERS-1:0] quota_mask_q;
   logic [REG_WIDTH-1:0]  quota_limit_q;
   logic                  int_ovf_q;
   logic                  int_quota_q;

   state_e                state_q, state_d;
   logic [SUM_W-1:0]      acc_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  acc_clr, acc_add, quota_hit, run;

   // ------------------------------------------------------------------
   // Counter next-state: softrst > write > increment > hold.
   // Overflow is only recognised on an increment-driven wrap.
   // ------------------------------------------------------------------
   always_comb begin
      ovf_status_d = ovf_status_q;
      for (int k = 0; k < N_COUNTERS; k++) begin
         cnt_d[k] = cnt_q[k];
         if (softrst) begin
            cnt_d[k] = '0;
         end else if (wrapper_we_i) begin
            cnt_d[k] = regs_i[k+1];
         end else if (en && events_i[k]) begin
            cnt_d[k] = cnt_q[k] + REG_WIDTH'(1);
            if ((&cnt_q[k]) && ovf_mask_q[k]) begin
               ovf_status_d[k] = 1'b1;
            end
         end
      end
      if (softrst) begin
         ovf_status_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < N_COUNTERS; k++) begin
            cnt_q[k] <= '0;
         end
         cfg_q         <= '0;
         ovf_mask_q    <= '0;
         ovf_status_q  <= '0;
         quota_mask_q  <= '0;
         quota_limit_q <= '0;
         int_ovf_q     <= 1'b0;
      end else begin
         for (int k = 0; k < N_COUNTERS; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
         ovf_status_q <= ovf_status_d;
         int_ovf_q    <= |ovf_status_q;
         if (wrapper_we_i) begin
            cfg_q         <= regs_i[0][1:0];
            ovf_mask_q    <= regs_i[OVF_MASK_I][N_COUNTERS-1:0];
            quota_mask_q  <= regs_i[Q_MASK_I][N_COUNTERS-1:0];
            quota_limit_q <= regs_i[Q_LIMIT_I];
         end
      end
   end

   // ------------------------------------------------------------------
   // Quota FSM: IDLE -> ACCUM (N cycles) -> COMPARE -> IDLE.
   // ------------------------------------------------------------------
   assign run = en && !softrst;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!run) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    state_d = S_ACCUM;
            S_ACCUM:   if (idx_q == IDX_W'(N_COUNTERS - 1)) state_d = S_COMPARE;
            S_COMPARE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      acc_clr   = run && (state_q == S_IDLE);
      acc_add   = run && (state_q == S_ACCUM) && quota_mask_q[idx_q];
      quota_hit = run && (state_q == S_COMPARE) && (acc_q > SUM_W'(quota_limit_q));
   end

   // Each counter is sampled live in its own ACCUM cycle, so writes made
   // during a scan are seen from the next sampled index onward.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         acc_q       <= '0;
         idx_q       <= '0;
         int_quota_q <= 1'b0;
      end else begin
         if (acc_clr) begin
            acc_q <= '0;
            idx_q <= '0;
         end else if (state_q == S_ACCUM) begin
            if (acc_add) begin
               acc_q <= acc_q + SUM_W'(cnt_q[idx_q]);
            end
            idx_q <= idx_q + IDX_W'(1);
         end
         if (softrst) begin
            int_quota_q <= 1'b0;
         end else if (quota_hit) begin
            int_quota_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Register read-back; unused bits read 0.
   // ------------------------------------------------------------------
   always_comb begin
      regs_o = '0;
      regs_o[0][1:0] = cfg_q;
      for (int k = 0; k < N_COUNTERS; k++) begin
         regs_o[k+1] = cnt_q[k];
      end
      regs_o[OVF_MASK_I][N_COUNTERS-1:0] = ovf_mask_q;
      regs_o[OVF_STAT_I][N_COUNTERS-1:0] = ovf_status_q;
      regs_o[Q_MASK_I][N_COUNTERS-1:0]   = quota_mask_q;
      regs_o[Q_LIMIT_I]                  = quota_limit_q;
   end

   assign int_overflow_o = int_ovf_q;
   assign int_quota_o    = int_quota_q;

endmodule

// File: tb/tb_pmu_core_ovq.sv
// tb/tb_pmu_core_ovq.sv - scoreboard testbench for pmu_core_ovq

module tb_pmu_core_ovq;

   localparam int RW       = 32;
   localparam int N        = 4;
   localparam int NR       = N + 5;
   localparam int SEL_IOVF = NR;
   localparam int SEL_IQ   = NR + 1;
   localparam int R_OMASK  = N + 1;
   localparam int R_OSTAT  = N + 2;
   localparam int R_QMASK  = N + 3;
   localparam int R_QLIM   = N + 4;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NR-1:0][RW-1:0]  regs_in;
   logic [NR-1:0][RW-1:0]  regs_out;
   logic                   we;
   logic [N-1:0]           events;
   logic                   int_ovf;
   logic                   int_q;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string          tag;
      int             sel;
      logic [RW-1:0]  exp;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pmu_core_ovq #(.REG_WIDTH(RW), .N_COUNTERS(N)) dut (
      .clk_i          (clk),
      .rstn_i         (rst_n),
      .regs_i         (regs_in),
      .regs_o         (regs_out),
      .wrapper_we_i   (we),
      .events_i       (events),
      .int_overflow_o (int_ovf),
      .int_quota_o    (int_q)
   );

   task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] observe(input int sel);
      if (sel < NR) return regs_out[sel];
      else if (sel == SEL_IOVF) return {{(RW-1){1'b0}}, int_ovf};
      else return {{(RW-1){1'b0}}, int_q};
   endfunction

   task automatic push_exp(input string tag, input int sel, input logic [RW-1:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_img();
      we = 1'b1;
      step(1);
      we = 1'b0;
   endtask

   task automatic clear_img();
      for (int i = 0; i < NR; i++) regs_in[i] = '0;
   endtask

   initial begin
      // Reset with garbage on every input
      for (int i = 0; i < NR; i++) regs_in[i] = 32'hA5A5_0000 + i + 3;
      we     = 1'b1;
      events = '1;
      step(3);
      for (int i = 0; i < NR; i++) push_exp($sformatf("rst_reg%0d", i), i, '0);
      push_exp("rst_iovf", SEL_IOVF, '0);
      push_exp("rst_iq", SEL_IQ, '0);
      drain();

      clear_img();
      we     = 1'b0;
      events = '0;
      step(1);
      rst_n = 1'b1;
      step(4);
      for (int i = 0; i < NR; i++) push_exp($sformatf("idle_reg%0d", i), i, '0);
      push_exp("idle_iovf", SEL_IOVF, '0);
      push_exp("idle_iq", SEL_IQ, '0);
      drain();

      // Counting on event 1
      clear_img();
      regs_in[0] = 32'd1;
      write_img();
      events[1] = 1'b1;
      step(10);
      events = '0;
      push_exp("cnt_c1", 2, 32'd10);
      push_exp("cnt_c0", 1, '0);
      push_exp("cnt_c2", 3, '0);
      push_exp("cnt_c3", 4, '0);
      push_exp("cnt_cfg", 0, 32'd1);
      drain();
      regs_in[0] = '0;
      events[1] = 1'b1;
      step(5);
      events = '0;
      push_exp("hold_c1", 2, 32'd10);
      drain();

      // Overflow with mask on
      clear_img();
      regs_in[0]       = 32'd1;
      regs_in[1]       = 32'hFFFF_FFFE;
      regs_in[R_OMASK] = 32'd1;
      write_img();
      events[0] = 1'b1;
      step(2);
      events = '0;
      push_exp("ovf_c0", 1, '0);
      push_exp("ovf_stat", R_OSTAT, 32'd1);
      push_exp("ovf_int_lag", SEL_IOVF, '0);
      drain();
      step(1);
      push_exp("ovf_int_rise", SEL_IOVF, 32'd1);
      drain();
      step(3);
      push_exp("ovf_int_hold", SEL_IOVF, 32'd1);
      drain();
      regs_in[0] = 32'd3;
      step(1);
      regs_in[0] = 32'd1;
      push_exp("ovf_stat_clr", R_OSTAT, '0);
      drain();
      step(1);
      push_exp("ovf_int_clr", SEL_IOVF, '0);
      push_exp("ovf_iq", SEL_IQ, '0);
      drain();

      // Overflow with mask off
      clear_img();
      regs_in[0] = 32'd1;
      regs_in[1] = 32'hFFFF_FFFE;
      write_img();
      events[0] = 1'b1;
      step(2);
      events = '0;
      step(2);
      push_exp("silent_c0", 1, '0);
      push_exp("silent_stat", R_OSTAT, '0);
      push_exp("silent_int", SEL_IOVF, '0);
      drain();

      // Quota exceeded: 60 + 41 > 100
      clear_img();
      step(1);
      regs_in[0]       = 32'd1;
      regs_in[1]       = 32'd60;
      regs_in[2]       = 32'd41;
      regs_in[R_QMASK] = 32'hFFFF_FFF3;
      regs_in[R_QLIM]  = 32'd100;
      write_img();
      push_exp("q_mask_rd", R_QMASK, 32'd3);
      push_exp("q_lim_rd", R_QLIM, 32'd100);
      drain();
      for (int c = 1; c < 6 && !int_q; c++) step(1);
      push_exp("q_fire", SEL_IQ, 32'd1);
      drain();

      // Sum equal to limit does not fire
      regs_in[0] = 32'd2;
      step(1);
      push_exp("q_softrst_clr", SEL_IQ, '0);
      drain();
      regs_in[0] = 32'd1;
      regs_in[2] = 32'd40;
      write_img();
      step(50);
      push_exp("q_equal", SEL_IQ, '0);
      push_exp("q_c0_kept", 1, 32'd60);
      drain();
      regs_in[3] = 32'd1000;
      write_img();
      step(20);
      push_exp("q_unmasked", SEL_IQ, '0);
      push_exp("q_c2", 3, 32'd1000);
      drain();

      // Write beats increment
      regs_in[1] = 32'd5;
      events[0]  = 1'b1;
      write_img();
      push_exp("prio_c0", 1, 32'd5);
      drain();
      events = '0;

      // softrst mid-scan discards the partial sum
      regs_in[0] = '0;
      step(1);
      regs_in[0] = 32'd1;
      regs_in[1] = 32'd60;
      regs_in[2] = 32'd41;
      regs_in[3] = '0;
      write_img();
      step(2);
      regs_in[0] = 32'd3;
      step(1);
      regs_in[0] = 32'd1;
      push_exp("abort_c0", 1, '0);
      push_exp("abort_c1", 2, '0);
      drain();
      step(20);
      push_exp("abort_iq", SEL_IQ, '0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
